// File: rtl/vx_split_join_ctrl.sv
// vx_split_join_ctrl: SPLIT/JOIN divergence controller driving per-warp IPDOM stacks
//  clk, reset                 clock, synchronous active-high reset
//  req_*                      op request (SPLIT/JOIN) from issue, accepted only in IDLE
//  rsp_*                      new thread mask / PC redirect / error back to the scheduler
//  stk_push/pop/pair/q1/q2    per-warp stack strobes and push data (driven in EXEC only)
//  stk_d/index/empty/full     per-warp stack top-of-stack and status
module vx_split_join_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 32,
  parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int WIDTH       = NUM_THREADS + PC_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_is_split,
  input  logic                       req_is_join,
  input  logic [WID_W-1:0]           req_wid,
  input  logic [NUM_THREADS-1:0]     req_tmask,
  input  logic [NUM_THREADS-1:0]     req_taken,
  input  logic [PC_W-1:0]            req_else_pc,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WID_W-1:0]           rsp_wid,
  output logic [NUM_THREADS-1:0]     rsp_tmask,
  output logic [PC_W-1:0]            rsp_pc,
  output logic                       rsp_jump,
  output logic                       rsp_err,
  output logic [NUM_WARPS-1:0]       stk_push,
  output logic [NUM_WARPS-1:0]       stk_pop,
  output logic                       stk_pair,
  output logic [WIDTH-1:0]           stk_q1,
  output logic [WIDTH-1:0]           stk_q2,
  input  logic [NUM_WARPS*WIDTH-1:0] stk_d,
  input  logic [NUM_WARPS-1:0]       stk_index,
  input  logic [NUM_WARPS-1:0]       stk_empty,
  input  logic [NUM_WARPS-1:0]       stk_full
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e                 state_q;
  logic                   split_q, join_q;
  logic [WID_W-1:0]       wid_q;
  logic [NUM_THREADS-1:0] tmask_q, taken_q;
  logic [PC_W-1:0]        else_pc_q;
  logic [WID_W-1:0]       rsp_wid_q;
  logic [NUM_THREADS-1:0] rsp_tmask_q, rsp_tmask_d;
  logic [PC_W-1:0]        rsp_pc_q, rsp_pc_d;
  logic                   rsp_jump_q, rsp_jump_d, rsp_err_q, rsp_err_d;
  logic [NUM_THREADS-1:0] t_mask, e_mask;
  logic [WIDTH-1:0]       top;
  logic                   is_split, is_join, full_w, empty_w, div, exec, do_push, do_pop;
  assign is_split = split_q & ~join_q;
  assign is_join  = join_q & ~split_q;
  assign t_mask   = taken_q & tmask_q;
  assign e_mask   = ~taken_q & tmask_q;
  assign div      = |t_mask && |e_mask;
  assign full_w   = stk_full[wid_q];
  assign empty_w  = stk_empty[wid_q];
  assign top      = stk_d[32'(wid_q)*WIDTH +: WIDTH];
  // reset gates the strobes combinationally so a reset landing in EXEC never reaches the stacks
  assign exec     = (state_q == EXEC) && !reset;
  assign do_push  = exec && is_split && !full_w;
  assign do_pop   = exec && is_join && !empty_w;
  assign stk_push = do_push ? NUM_WARPS'(1) << wid_q : '0;
  assign stk_pop  = do_pop ? NUM_WARPS'(1) << wid_q : '0;
  assign stk_pair = do_push && div;
  assign stk_q1   = do_push ? {tmask_q, PC_W'(0)} : '0;
  assign stk_q2   = (do_push && div) ? {e_mask, else_pc_q} : '0;
  // index=0 means the top is the else entry, which needs a redirect; restore entries do not
  assign rsp_err_d   = is_split ? full_w : is_join ? empty_w : 1'b1;
  assign rsp_jump_d  = is_join && !empty_w && !stk_index[wid_q];
  assign rsp_pc_d    = rsp_jump_d ? top[PC_W-1:0] : '0;
  assign rsp_tmask_d = rsp_err_d ? tmask_q : is_split ? (div ? t_mask : tmask_q) : top[WIDTH-1:PC_W];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_wid   = rsp_wid_q;
  assign rsp_tmask = rsp_tmask_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_jump  = rsp_jump_q;
  assign rsp_err   = rsp_err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      split_q     <= 1'b0;
      join_q      <= 1'b0;
      wid_q       <= '0;
      tmask_q     <= '0;
      taken_q     <= '0;
      else_pc_q   <= '0;
      rsp_wid_q   <= '0;
      rsp_tmask_q <= '0;
      rsp_pc_q    <= '0;
      rsp_jump_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          split_q   <= req_is_split;
          join_q    <= req_is_join;
          wid_q     <= req_wid;
          tmask_q   <= req_tmask;
          taken_q   <= req_taken;
          else_pc_q <= req_else_pc;
          state_q   <= EXEC;
        end
        EXEC: begin
          rsp_wid_q   <= wid_q;
          rsp_tmask_q <= rsp_tmask_d;
          rsp_pc_q    <= rsp_pc_d;
          rsp_jump_q  <= rsp_jump_d;
          rsp_err_q   <= rsp_err_d;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
